// File: rtl/odd_parity_serial_tx.sv
// odd_parity_serial_tx: UART-style transmitter sending start, data (LSB first), odd parity and stop bits
module odd_parity_serial_tx #(
   parameter int width     = 8,
   parameter int divider   = 16,
   parameter int stop_bits = 1
) (
   input  logic             clk,
   input  logic             rst_x,
   input  logic [width-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_tx
);
   localparam int cw = divider > 1 ? $clog2(divider) : 1;
   localparam int bw = width > 2 ? $clog2(width) : 1;
   localparam logic [cw-1:0] cnt_max = cw'(divider - 1);
   localparam logic [bw-1:0] last_bit = bw'(width - 1);
   localparam logic [bw-1:0] last_stop = bw'(stop_bits - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t           state;
   logic [cw-1:0]    cnt;
   logic [bw-1:0]    idx;
   logic [width-1:0] shift;
   logic [width-1:0] next_shift;
   logic             par;
   logic             bit_end;
   assign bit_end    = cnt == cnt_max;
   assign next_shift = shift >> 1;
   assign o_ready    = state == IDLE;
   // frame sequencer; o_tx is registered so the line level for a bit is set at the edge that enters it
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         par   <= 1'b0;
         o_tx  <= 1'b1;
      end else begin
         cnt <= (state == IDLE || bit_end) ? '0 : cnt + cw'(1);
         case (state)
            IDLE: begin
               o_tx <= !i_valid;
               if (i_valid) begin
                  shift <= i_data;
                  par   <= ~^i_data;
                  idx   <= '0;
                  state <= START;
               end
            end
            START: if (bit_end) begin
               state <= DATA;
               o_tx  <= shift[0];
            end
            DATA: if (bit_end) begin
               shift <= next_shift;
               if (idx == last_bit) begin
                  state <= PARITY;
                  o_tx  <= par;
               end else begin
                  idx  <= idx + bw'(1);
                  o_tx <= next_shift[0];
               end
            end
            PARITY: if (bit_end) begin
               state <= STOP;
               idx   <= '0;
               o_tx  <= 1'b1;
            end
            STOP: if (bit_end) begin
               if (idx == last_stop) state <= IDLE;
               else idx <= idx + bw'(1);
            end
            default: begin
               state <= IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// tb_odd_parity_serial_tx: frame-level model check plus directed literal vectors for the serial transmitter
module tb_odd_parity_serial_tx;
   localparam int FA = (2 + 8 + 1) * 4;
   localparam int FB = (2 + 8 + 2) * 1;
   logic clk = 1'b0;
   logic rst_a, rst_b, valid_a, valid_b, ready_a, ready_b, tx_a, tx_b;
   logic [7:0] data_a, data_b, md_a, md_b;
   int pos_a = -1, pos_b = -1;
   int tests = 0, fails = 0;
   bit chk = 1'b0;
   always #5 clk = ~clk;
   odd_parity_serial_tx #(.width(8), .divider(4), .stop_bits(1)) dut_a (
      .clk(clk), .rst_x(rst_a), .i_data(data_a), .i_valid(valid_a), .o_ready(ready_a), .o_tx(tx_a));
   odd_parity_serial_tx #(.width(8), .divider(1), .stop_bits(2)) dut_b (
      .clk(clk), .rst_x(rst_b), .i_data(data_b), .i_valid(valid_b), .o_ready(ready_b), .o_tx(tx_b));
   task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask
   // line level for cycle pos of a frame carrying d: bit slot = pos/div
   function automatic logic exp_tx(input logic [7:0] d, input int pos, input int div);
      int b;
      if (pos < 0) return 1'b1;
      b = pos / div;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == 9) return ($countones(d) % 2) == 0;
      return 1'b1;
   endfunction
   // frame position model for each instance
   always @(posedge clk or negedge rst_a)
      if (!rst_a) pos_a <= -1;
      else if (pos_a < 0) begin
         if (valid_a) begin
            pos_a <= 0;
            md_a  <= data_a;
         end
      end else pos_a <= (pos_a == FA - 1) ? -1 : pos_a + 1;
   always @(posedge clk or negedge rst_b)
      if (!rst_b) pos_b <= -1;
      else if (pos_b < 0) begin
         if (valid_b) begin
            pos_b <= 0;
            md_b  <= data_b;
         end
      end else pos_b <= (pos_b == FB - 1) ? -1 : pos_b + 1;
   // per-cycle comparison against the model
   always @(negedge clk)
      if (chk) begin
         check("tx_a", tx_a, exp_tx(md_a, pos_a, 4));
         check("ready_a", ready_a, pos_a < 0);
         check("tx_b", tx_b, exp_tx(md_b, pos_b, 1));
         check("ready_b", ready_b, pos_b < 0);
      end
   task automatic send_a(input logic [7:0] d, output logic [10:0] seq, output int low, output logic back);
      @(negedge clk);
      valid_a = 1'b1;
      data_a  = d;
      @(posedge clk);
      low = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 1) valid_a = 1'b0;
         if (c <= 44) begin
            if ((c - 1) % 4 == 0) seq[(c-1)/4] = tx_a;
            low += int'(!ready_a);
         end else back = ready_a;
      end
   endtask
   task automatic send_b(input logic [7:0] d, output logic [11:0] bits, output int low, output logic back);
      @(negedge clk);
      valid_b = 1'b1;
      data_b  = d;
      @(posedge clk);
      low = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) valid_b = 1'b0;
         bits[i] = tx_b;
         low += int'(!ready_b);
      end
      @(negedge clk);
      back = ready_b;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin
      logic [10:0] seq;
      logic [11:0] bits;
      logic back, prev;
      int low, idle, n2;
      rst_a = 1'b1; rst_b = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0;
      data_a = '0; data_b = '0;
      #2;
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_tx_a", tx_a, 1);
      check("reset_ready_a", ready_a, 1);
      check("reset_tx_b", tx_b, 1);
      check("reset_ready_b", ready_b, 1);
      rst_a = 1'b1; rst_b = 1'b1;
      chk = 1'b1;
      send_a(8'hA5, seq, low, back);
      check("a5_seq", seq, 11'b11101001010);
      check("a5_ready_low", low, 44);
      check("a5_ready_back", back, 1);
      send_b(8'h01, bits, low, back);
      check("par_01", bits[9], 0);
      send_b(8'h00, bits, low, back);
      check("par_00", bits[9], 1);
      send_b(8'hFF, bits, low, back);
      check("par_ff", bits[9], 1);
      send_b(8'h80, bits, low, back);
      check("b80_frame", bits, 12'b110100000000);
      check("b80_ready_low", low, 12);
      check("b80_ready13", back, 1);
      for (int i = 0; i < 1000; i++) begin
         send_b(8'($urandom), bits, low, back);
         check("odd_ones", $countones(bits[9:1]) % 2, 1);
      end
      @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      data_a = 8'hC3;
      check("b2b_first_start", tx_a, 0);
      idle = 0; n2 = -1; prev = ready_a;
      for (int n = 1; n <= 60 && n2 < 0; n++) begin
         @(negedge clk);
         if (ready_a) idle++;
         if (!ready_a && prev) n2 = n;
         prev = ready_a;
      end
      valid_a = 1'b0;
      check("b2b_gap", n2, 45);
      check("b2b_idle", idle, 1);
      repeat (10) @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'hFF;
      @(negedge clk);
      valid_a = 1'b0;
      repeat (40) @(negedge clk);
      check("third_ignored", ready_a, 1);
      @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'hF0;
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      repeat (17) @(negedge clk);
      check("pre_rst_tx", tx_a, 0);
      #1 rst_a = 1'b0;
      #1;
      check("rst_async_tx", tx_a, 1);
      check("rst_async_ready", ready_a, 1);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      send_a(8'h5A, seq, low, back);
      check("5a_seq", seq, 11'b11010110100);
      check("5a_ready_low", low, 44);
      check("5a_ready_back", back, 1);
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
